mux_arb_n: RTL and testbench
============================

# mux_arb_n

Parametrised, registered N-to-1 multiplexer with valid/ready handshake and built-in arbitration. It generalises the fixed-width, fixed-depth select-driven mux trees in the ALU into a buffered channel selector. Each cycle it picks one requesting input (round-robin or fixed-priority), or a software-forced input, and captures it into a single output register. It sits between multiple producers (ALU result sources, memory-mapped peripherals) and one shared consumer.

## Interface
Parameters:
- WIDTH, 32, data width per channel
- N, 8, number of input channels (1..64, need not be a power of 2)
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
- SEL_W (localparam), max(1, $clog2(N)), width of channel index

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  N  per-channel request
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot or zero; channel i transfers when in_valid[i] & in_ready[i]
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  captured word
- out_sel  output  SEL_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready
- force_en  input  1  override arbitration with force_sel
- force_sel  input  SEL_W  channel forced when force_en = 1

## Operation
- accept = ~out_valid | out_ready (register empty or draining this cycle).
- Candidate set: force_en=1 → only channel force_sel, and only if in_valid[force_sel]; force_sel ≥ N → empty set. force_en=0 → all i with in_valid[i].
- Winner g: ROUND_ROBIN=1 → first candidate scanning last+1, last+2, … mod N; ROUND_ROBIN=0 → lowest candidate index.
- in_ready[g] = accept & (candidate set non-empty); all other in_ready bits 0. in_ready is 0 while reset is asserted.
- On transfer: out_data ← in_data[g], out_sel ← g, out_valid ← 1. In round-robin mode only, last ← g.
- On drain without load (out_valid & out_ready, no transfer): out_valid ← 0. out_data and out_sel hold their values.
- Forced grants update last in round-robin mode, as with normal grants.
- Reset values: out_valid=0, out_data=0, out_sel=0, last=N-1 (the first scan starts at channel 0).
- N=1: always selects channel 0; the last pointer is constant.

## Timing
- Latency: input transfer at edge k → out_valid=1 with the data after edge k.
- Throughput: one word per cycle when out_ready is held at 1 (simultaneous drain and load).
- out_ready=0 with out_valid=1: register holds; all in_ready=0 (backpressure).
- Producers hold in_valid and in_data stable until their transfer. in_ready may depend combinationally on in_valid, out_ready, force_en and force_sel. out_valid and out_data never depend combinationally on inputs.
- Wrap-around: a scan past N-1 continues at 0. Non-power-of-2 N never produces an index ≥ N.
- Reset mid-operation: a held word is discarded and out_valid drops asynchronously. After release, arbitration restarts at channel 0.

## Structure
- Shared package: the WIDTH default and the SEL_W derivation function (clog2 with minimum 1), reused by other parametrised ALU muxes.
- Sub-module mux_n: a purely combinational parametrised N-way WIDTH-bit selector (index → word). It replaces the fixed mux trees and is instantiated once for the data path.
- Arbitration, the last pointer and the output register live in mux_arb_n itself.

## Test plan
- Reset: assert reset mid-transfer with out_valid=1 → out_valid, out_data and out_sel read 0 immediately. First grant after release goes to channel 0 when all channels are valid.
- Round-robin fairness: N=8, all in_valid=1, out_ready=1 → out_sel sequence 0,1,…,7,0 on consecutive cycles, one transfer per cycle.
- Fixed priority: ROUND_ROBIN=0, in_valid=8'b1010_0100 → out_sel=2 every cycle while channel 2 stays valid.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and out_data constant. Raising out_ready yields a drain and a new load on the same edge.
- Force: force_en=1, force_sel=5, in_valid[5]=1, others valid → only in_ready[5]=1, out_sel=5. force_sel=6 with N=6 → no grant, out_valid falls after the drain.
- Non-power-of-2 wrap: N=5, last=4, in_valid=5'b00011 → grant channel 0, then channel 1.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// Shared definitions for the parametrised ALU channel multiplexers:
// default data width and the channel-index width derivation.
package mux_arb_n_pkg;

    localparam int DEF_WIDTH = 32;

    // Channel-index width: ceil(log2(n)), but never narrower than one bit.
    function automatic int sel_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mux_n.sv
// Purely combinational N-way word selector (index -> word); an index with
// no matching channel yields zero.
module mux_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = 8,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) word = data[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// Registered N-to-1 channel selector with valid/ready handshake and
// round-robin, fixed-priority or software-forced arbitration.
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 1,
    localparam int SEL_W      = sel_w(N)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready,
    input  logic                 force_en,
    input  logic [SEL_W-1:0]     force_sel
);

    // One spare bit so last + N never overflows before the wrap subtraction.
    localparam int IW = SEL_W + 1;

    logic [N-1:0]     cand;
    logic             any;
    logic             accept;
    logic             load;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] last;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] word;

    always_comb begin
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand[i] = force_en ? (in_valid[i] && (force_sel == SEL_W'(i))) : in_valid[i];
        end
        any = |cand;
    end

    // Scan downward so the candidate closest after last is written last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        if (ROUND_ROBIN != 0) begin
            for (int i = N; i >= 1; i--) begin
                idx = {1'b0, last} + IW'(i);
                if (idx >= IW'(N)) idx = idx - IW'(N);
                if (cand[idx[SEL_W-1:0]]) grant = idx[SEL_W-1:0];
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) grant = SEL_W'(i);
            end
        end
    end

    assign accept = ~out_valid | out_ready;
    assign load   = accept & any & ~reset;

    always_comb begin
        in_ready        = '0;
        in_ready[grant] = load;
    end

    mux_n #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_mux (
        .data (in_data),
        .sel  (grant),
        .word (word)
    );

    // Output register stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= SEL_W'(N - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_sel   <= grant;
            if (ROUND_ROBIN != 0) last <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_n.sv
// Scoreboard bench for mux_arb_n: three instances (N=8 round-robin,
// N=8 fixed priority, N=5 round-robin) driven with directed vectors.
module tb_mux_arb_n;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int qa[$];
    int qb[$];
    int qc[$];
    int ea, eb, ec;

    // Instance A: N=8, round-robin
    logic            rst_a;
    logic [7:0]      a_in_valid, a_in_ready;
    logic [8*W-1:0]  a_in_data;
    logic            a_out_valid, a_out_ready, a_force_en;
    logic [W-1:0]    a_out_data;
    logic [2:0]      a_out_sel, a_force_sel;

    // Instance B: N=8, fixed priority
    logic            rst_bc;
    logic [7:0]      b_in_valid, b_in_ready;
    logic [8*W-1:0]  b_in_data;
    logic            b_out_valid, b_out_ready, b_force_en;
    logic [W-1:0]    b_out_data;
    logic [2:0]      b_out_sel, b_force_sel;

    // Instance C: N=5, round-robin
    logic [4:0]      c_in_valid, c_in_ready;
    logic [5*W-1:0]  c_in_data;
    logic            c_out_valid, c_out_ready, c_force_en;
    logic [W-1:0]    c_out_data;
    logic [2:0]      c_out_sel, c_force_sel;

    mux_arb_n #(.WIDTH(W), .N(8), .ROUND_ROBIN(1)) u_a (
        .clock(clk), .reset(rst_a), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_sel(a_out_sel), .out_ready(a_out_ready), .force_en(a_force_en),
        .force_sel(a_force_sel)
    );

    mux_arb_n #(.WIDTH(W), .N(8), .ROUND_ROBIN(0)) u_b (
        .clock(clk), .reset(rst_bc), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_sel(b_out_sel), .out_ready(b_out_ready), .force_en(b_force_en),
        .force_sel(b_force_sel)
    );

    mux_arb_n #(.WIDTH(W), .N(5), .ROUND_ROBIN(1)) u_c (
        .clock(clk), .reset(rst_bc), .in_valid(c_in_valid), .in_data(c_in_data),
        .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
        .out_sel(c_out_sel), .out_ready(c_out_ready), .force_en(c_force_en),
        .force_sel(c_force_sel)
    );

    function automatic logic [W-1:0] pat(input int d, input int i);
        return {4'(d), 4'(i), 8'(8'h5A ^ 8'(i))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: output word with no expected entry", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare whenever a word leaves a DUT.
    always @(negedge clk) begin
        if (!rst_a && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) fail_now("a_extra");
            else begin
                ea = qa.pop_front();
                check("a_sel", 32'(a_out_sel), 32'(ea));
                check("a_data", 32'(a_out_data), 32'(pat(1, ea)));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_bc && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) fail_now("b_extra");
            else begin
                eb = qb.pop_front();
                check("b_sel", 32'(b_out_sel), 32'(eb));
                check("b_data", 32'(b_out_data), 32'(pat(2, eb)));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_bc && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) fail_now("c_extra");
            else begin
                ec = qc.pop_front();
                check("c_sel", 32'(c_out_sel), 32'(ec));
                check("c_data", 32'(c_out_data), 32'(pat(3, ec)));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; rst_bc = 1'b1;
        a_in_valid = '0; a_out_ready = 1'b0; a_force_en = 1'b0; a_force_sel = '0;
        b_in_valid = '0; b_out_ready = 1'b0; b_force_en = 1'b0; b_force_sel = '0;
        c_in_valid = '0; c_out_ready = 1'b0; c_force_en = 1'b0; c_force_sel = '0;
        for (int i = 0; i < 8; i++) a_in_data[i*W +: W] = pat(1, i);
        for (int i = 0; i < 8; i++) b_in_data[i*W +: W] = pat(2, i);
        for (int i = 0; i < 5; i++) c_in_data[i*W +: W] = pat(3, i);

        // Reset state; in_ready stays low while reset is held even with requests.
        a_in_valid = 8'hFF; a_out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_sel", 32'(a_out_sel), 32'd0);
        check("rst_out_data", 32'(a_out_data), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        tick();
        tick();

        // Round-robin fairness: 0..7 then wrap to 0, one word per cycle.
        for (int k = 0; k < 9; k++) qa.push_back(k % 8);
        rst_a = 1'b0; rst_bc = 1'b0;
        #1;
        check("rr_first_ready", 32'(a_in_ready), 32'h01);
        repeat (9) tick();
        a_in_valid = '0;
        tick();
        check("rr_drained", 32'(a_out_valid), 32'd0);

        // Backpressure: word from channel 1 held for 3 cycles.
        a_in_valid = 8'b0000_0110; a_out_ready = 1'b0;
        qa.push_back(1);
        tick();
        a_in_valid = 8'b0000_0100;
        repeat (3) begin
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_out_data", 32'(a_out_data), 32'(pat(1, 1)));
            tick();
        end
        a_out_ready = 1'b1;
        qa.push_back(2);
        #1;
        check("bp_release_ready", 32'(a_in_ready), 32'h04);
        tick();
        a_in_valid = '0;
        tick();

        // Force channel 5; the forced grant moves last, so the next scan starts at 6.
        a_in_valid = 8'hFF; a_force_en = 1'b1; a_force_sel = 3'd5;
        #1;
        check("force_ready", 32'(a_in_ready), 32'h20);
        qa.push_back(5);
        tick();
        a_force_en = 1'b0;
        #1;
        check("force_then_rr", 32'(a_in_ready), 32'h40);
        qa.push_back(6);
        tick();
        a_in_valid = '0;
        tick();

        // Reset while a word (channel 7) is held under backpressure.
        a_in_valid = 8'hFF; a_out_ready = 1'b0;
        tick();
        check("pre_rst_valid", 32'(a_out_valid), 32'd1);
        check("pre_rst_sel", 32'(a_out_sel), 32'd7);
        rst_a = 1'b1;
        #1;
        check("mid_rst_valid", 32'(a_out_valid), 32'd0);
        check("mid_rst_data", 32'(a_out_data), 32'd0);
        check("mid_rst_sel", 32'(a_out_sel), 32'd0);
        check("mid_rst_ready", 32'(a_in_ready), 32'd0);
        tick();
        rst_a = 1'b0; a_out_ready = 1'b1;
        qa.push_back(0);
        #1;
        check("post_rst_ready", 32'(a_in_ready), 32'h01);
        tick();
        a_in_valid = '0;
        tick();

        // Fixed priority: channel 2 wins while it stays valid, then 5.
        b_in_valid = 8'b1010_0100; b_out_ready = 1'b1;
        repeat (4) begin
            #1;
            check("fp_ready2", 32'(b_in_ready), 32'h04);
            qb.push_back(2);
            tick();
        end
        b_in_valid = 8'b1010_0000;
        #1;
        check("fp_ready5", 32'(b_in_ready), 32'h20);
        qb.push_back(5);
        tick();
        b_in_valid = '0;
        tick();
        tick();

        // N=5: first scan from last=4 wraps to 0, then 1; later 3,4 and wrap back to 3.
        c_in_valid = 5'b00011; c_out_ready = 1'b1;
        #1;
        check("n5_first_ready", 32'(c_in_ready), 32'h01);
        qc.push_back(0);
        tick();
        qc.push_back(1);
        tick();
        c_in_valid = 5'b11000;
        qc.push_back(3);
        tick();
        qc.push_back(4);
        tick();
        qc.push_back(3);
        tick();
        // Forcing a channel index beyond N gives no grant; the held word drains.
        c_force_en = 1'b1; c_force_sel = 3'd6; c_in_valid = 5'b11111;
        #1;
        check("force_oob_ready", 32'(c_in_ready), 32'd0);
        tick();
        check("force_oob_valid", 32'(c_out_valid), 32'd0);
        c_in_valid = '0; c_force_en = 1'b0;
        tick();

        check("qa_empty", 32'(qa.size()), 32'd0);
        check("qb_empty", 32'(qb.size()), 32'd0);
        check("qc_empty", 32'(qc.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
